bb_feeder: RTL and testbench

Upstream stage of the baseball scorer. Accepts one play-action code per handshake from the game-script source, annotates each action with inning and half by tracking outs and first-base occupancy, and buffers the annotated actions for a whole game. Replays the buffered game to the scorer as one gap-free `in_valid` burst, then waits for the scorer's `out_valid` before loading the next game.

---
 rtl/bb_feeder.sv | 158 +++++++++++++++
 tb/tb_bb_feeder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bb_feeder.sv
// bb_feeder: tags play actions with inning/half, buffers one game, replays it as a burst.
// Optional sticky overflow flag port ovf_err enabled by BB_FEED_OVF_ERR_EN.
module bb_feeder #(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       act_valid,
  input  logic [2:0] act,
  output logic       act_ready,
  input  logic       res_valid,
  output logic       in_valid,
  output logic [1:0] inning,
  output logic       half,
  output logic [2:0] action,
  output logic       game_busy
`ifdef BB_FEED_OVF_ERR_EN
  ,
  output logic       ovf_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    WAIT_RES
  } state_t;

  state_t         state;
  logic [5:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  logic [1:0]     outs;
  logic           first;
  logic [1:0]     cur_inning;
  logic           cur_half;

  logic           full;
  logic           accept;
  logic [1:0]     add_outs;
  logic           nfirst;
  logic [2:0]     tot;
  logic           retire;
  logic           final_act;
  logic           fill;

  assign full      = (count == CW'(DEPTH));
  assign act_ready = (state == LOAD) && !full;
  assign accept    = act_valid && act_ready;
  assign game_busy = (state != LOAD);

  // Per-action effect on first base and outs, plus retirement decode
  always_comb begin
    add_outs = 2'd0;
    nfirst   = first;
    case (act)
      3'd0, 3'd1: nfirst = 1'b1;
      3'd2, 3'd3, 3'd4: nfirst = 1'b0;
      3'd5: begin
        nfirst   = 1'b0;
        add_outs = 2'd1;
      end
      3'd6: begin
        add_outs = first ? 2'd2 : 2'd1;
        nfirst   = 1'b0;
      end
      default: add_outs = 2'd1;
    endcase
    tot       = {1'b0, outs} + {1'b0, add_outs};
    retire    = (tot >= 3'd3);
    final_act = retire && (cur_inning == 2'd3) && cur_half;
    fill      = (count == CW'(DEPTH - 1));
  end

  // Game buffer storage; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {cur_inning, cur_half, act};
  end

  // Load/stream/wait sequencer, tracker and registered scorer outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      outs       <= 2'd0;
      first      <= 1'b0;
      cur_inning <= 2'd1;
      cur_half   <= 1'b0;
      in_valid   <= 1'b0;
      inning     <= 2'd0;
      half       <= 1'b0;
      action     <= 3'd0;
`ifdef BB_FEED_OVF_ERR_EN
      ovf_err    <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          in_valid <= 1'b0;
          if (accept) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + CW'(1);
            if (final_act || fill) begin
              state      <= STREAM;
              outs       <= 2'd0;
              first      <= 1'b0;
              cur_inning <= 2'd1;
              cur_half   <= 1'b0;
`ifdef BB_FEED_OVF_ERR_EN
              if (!final_act) ovf_err <= 1'b1;
`endif
            end else if (retire) begin
              outs  <= 2'd0;
              first <= 1'b0;
              if (!cur_half) begin
                cur_half <= 1'b1;
              end else begin
                cur_half   <= 1'b0;
                cur_inning <= cur_inning + 2'd1;
              end
            end else begin
              outs  <= tot[1:0];
              first <= nfirst;
            end
          end
        end
        STREAM: begin
          if (count != '0) begin
            {inning, half, action} <= mem[rd_ptr];
            in_valid <= 1'b1;
            rd_ptr   <= rd_ptr + AW'(1);
            count    <= count - CW'(1);
            if (count == CW'(1)) state <= WAIT_RES;
          end else begin
            in_valid <= 1'b0;
            state    <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          in_valid <= 1'b0;
          if (res_valid) state <= LOAD;
        end
        default: begin
          in_valid <= 1'b0;
          state    <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bb_feeder.sv
// tb_bb_feeder: directed games checked against hand-tagged entries.
// Covers tagging, burst timing, handshake, truncation and reset.
module tb_bb_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       act_valid = 1'b0;
  logic [2:0] act = 3'd0;
  logic       res_valid = 1'b0;
  logic       act_ready;
  logic       in_valid;
  logic [1:0] inning;
  logic       half;
  logic [2:0] action;
  logic       game_busy;
  logic       ovf_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_last = 0;
  logic ovf_pre = 1'b0;
  logic ovf_post = 1'b0;

  logic [5:0] beats[$];
  int         beat_cyc[$];
  logic [2:0] act_q[$];
  logic [5:0] exp_q[$];

  bb_feeder #(.DEPTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .act_valid (act_valid),
    .act       (act),
    .act_ready (act_ready),
    .res_valid (res_valid),
    .in_valid  (in_valid),
    .inning    (inning),
    .half      (half),
    .action    (action),
    .game_busy (game_busy)
`ifdef BB_FEED_OVF_ERR_EN
    ,
    .ovf_err   (ovf_err)
`endif
  );

`ifndef BB_FEED_OVF_ERR_EN
  assign ovf_err = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (in_valid) begin
      beats.push_back({inning, half, action});
      beat_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] a);
    int n;
    n = 0;
    act_valid = 1'b1;
    act = a;
    while (!act_ready && n < 100) begin
      tick;
      n++;
    end
    if (n >= 100) chk("send_timeout", 0, 1);
    t_last = cyc;
    tick;
    act_valid = 1'b0;
  endtask

  function automatic logic [5:0] ent(input int inn, input int h,
                                     input int a);
    return {inn[1:0], h[0], a[2:0]};
  endfunction

  task automatic add(input int a, input int inn, input int h);
    act_q.push_back(a[2:0]);
    exp_q.push_back(ent(inn, h, a));
  endtask

  task automatic add_flies(input int hstart, input int n);
    int hi;
    for (int j = 0; j < n; j++) begin
      hi = hstart + j / 3;
      add(7, hi / 2 + 1, hi % 2);
    end
  endtask

  task automatic play(input bit gaps, input bit res_in_stream);
    int base;
    int n;
    int last;
    base = beats.size();
    foreach (act_q[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick;
      if (i == act_q.size() - 1) ovf_pre = ovf_err;
      send(act_q[i]);
    end
    ovf_post = ovf_err;
    chk("stream_ready", act_ready, 0);
    chk("stream_busy", game_busy, 1);
    if (res_in_stream) begin
      res_valid = 1'b1;
      tick;
      res_valid = 1'b0;
    end
    n = 0;
    while ((beats.size() < base + exp_q.size() || in_valid)
           && n < 200) begin
      tick;
      n++;
    end
    if (n >= 200) chk("burst_timeout", 0, 1);
    chk("burst_len", beats.size() - base, exp_q.size());
    if (beats.size() > base) begin
      last = beat_cyc.size() - 1;
      chk("burst_start", beat_cyc[base], t_last + 2);
      chk("burst_end", beat_cyc[last], t_last + exp_q.size() + 1);
    end
    foreach (exp_q[i]) begin
      if (base + i < beats.size())
        chk($sformatf("entry%0d", i), beats[base + i], exp_q[i]);
    end
    chk("wait_ready", act_ready, 0);
    chk("wait_busy", game_busy, 1);
    chk("hold_fields", {inning, half, action}, exp_q[exp_q.size() - 1]);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic release_res(input int hold);
    repeat (hold) begin
      tick;
      chk("hold_ready", act_ready, 0);
    end
    res_valid = 1'b1;
    tick;
    res_valid = 1'b0;
    chk("res_ready", act_ready, 1);
    chk("res_busy", game_busy, 0);
  endtask

  initial begin
    int n;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("rst_ready", act_ready, 1);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_inning", inning, 0);
    chk("rst_half", half, 0);
    chk("rst_action", action, 0);
    chk("rst_busy", game_busy, 0);
    chk("rst_ovf", ovf_err, 0);

    // minimal game of 18 fly balls
    add_flies(0, 18);
    play(1'b0, 1'b0);
    release_res(2);

    // double play in the top of the 1st, random gaps, stray res_valid
    add(1, 1, 0);
    add(6, 1, 0);
    add(7, 1, 0);
    add_flies(1, 15);
    play(1'b1, 1'b1);
    release_res(10);

    // ground balls with nobody on
    add(2, 1, 0);
    add(6, 1, 0);
    add(6, 1, 0);
    add(6, 1, 0);
    add(0, 1, 1);
    add_flies(1, 3);
    add_flies(2, 12);
    play(1'b0, 1'b0);
    release_res(1);

    // 32 walks fill the buffer and truncate the game
    for (int i = 0; i < 32; i++) add(0, 1, 0);
    play(1'b0, 1'b0);
`ifdef BB_FEED_OVF_ERR_EN
    chk("ovf_before", ovf_pre, 0);
    chk("ovf_after", ovf_post, 1);
`endif
    release_res(1);

    // reset during the 5th burst beat
    add_flies(0, 18);
    foreach (act_q[i]) send(act_q[i]);
    act_q.delete();
    exp_q.delete();
    n = 0;
    while (cyc < t_last + 6 && n < 50) begin
      tick;
      n++;
    end
    chk("mid_in_valid_pre", in_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_in_valid", in_valid, 0);
    chk("mid_busy", game_busy, 0);
    #10;
    rst_n = 1'b1;
    tick;
    chk("post_ready", act_ready, 1);
    chk("post_in_valid", in_valid, 0);

    // next game streams only its own actions
    add(1, 1, 0);
    add(6, 1, 0);
    add(7, 1, 0);
    add_flies(1, 15);
    play(1'b0, 1'b0);
    release_res(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
